data_ram_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-port data memory between two requesters: port 0 (core load/store path) and port 1 (DMA / memory-init loader).
- Accepts req/ack transactions from each port, grants one at a time (round-robin or fixed priority), and drives the memory's MemRead/MemWrite/Address/DataSrc signals.
- Captures read data from the memory's combinational DataMemOut into a per-port registered output.

---
 rtl/data_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Shares one single-port data memory between two requesters: port 0 (core
// load/store path) and port 1 (DMA / memory-init loader). Each port raises
// Req with We/Addr/WData and holds it until it sees a one-cycle Ack. One
// transaction is granted at a time and runs IDLE -> ACCESS -> DONE, so the
// memory sees at most one access every three cycles.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   Req0/We0/Addr0/WData0 port 0 request, direction, address, write data
//   Ack0, RData0          port 0 completion pulse, last read data (held)
//   Req1/We1/Addr1/WData1 port 1 request, direction, address, write data
//   Ack1, RData1          port 1 completion pulse, last read data (held)
//   MemRead, MemWrite     memory enables, only high during ACCESS
//   Address, DataSrc      memory address / write data (hold outside ACCESS)
//   DataMemOut            combinational memory read data
//
// Parameters
//   ADDR_W, DATA_W        address and data widths
//   FIXED_PRIO            0: round-robin on ties, 1: port 0 wins ties
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ack0,
    output logic [DATA_W-1:0] RData0,

    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,

    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataSrc,
    input  logic [DATA_W-1:0] DataMemOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_src_q, data_src_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              winner;

    // Port chosen when at least one request is present. On a tie the
    // round-robin mode hands the grant to the port that did not win last.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last);
        if (req0 && req1) begin
            return (FIXED_PRIO != 0) ? 1'b0 : ~last;
        end
        return req1;
    endfunction

    assign winner = pick_winner(Req0, Req1, last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        address_d    = address_q;
        data_src_d   = data_src_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_d      = ACCESS;
                    grant_d      = winner;
                    last_grant_d = winner;
                    // The registered enables/address/data double as the
                    // latched copy of the granted transaction.
                    if (winner) begin
                        mem_write_d = We1;
                        mem_read_d  = ~We1;
                        address_d   = Addr1;
                        data_src_d  = WData1;
                    end else begin
                        mem_write_d = We0;
                        mem_read_d  = ~We0;
                        address_d   = Addr0;
                        data_src_d  = WData0;
                    end
                end
            end

            ACCESS: begin
                state_d = DONE;
                if (grant_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                if (mem_read_q) begin
                    if (grant_q) begin
                        rdata1_d = DataMemOut;
                    end else begin
                        rdata0_d = DataMemOut;
                    end
                end
            end

            // Requests are not looked at here; a Req still high is picked
            // up again from IDLE on the following cycle.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Asynchronous reset drops MemWrite immediately, so an access cut off
    // by reset never commits at the next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            address_q    <= '0;
            data_src_q   <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            address_q    <= address_d;
            data_src_q   <= data_src_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign Address  = address_q;
    assign DataSrc  = data_src_q;
    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign RData0   = rdata0_q;
    assign RData1   = rdata1_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for data_ram_arbiter. Instance "a" is round-robin and carries a
// simple memory model; instance "b" uses fixed priority with a read-only
// memory pattern. Each Ack is checked against a queue of expected
// completions (port, RData0, RData1) filled when the request is issued.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       port;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;

    // ---------------- instance a (round-robin) ----------------
    logic       rst_n_a;
    logic       req0_a, we0_a, req1_a, we1_a;
    logic [7:0] addr0_a, wdata0_a, addr1_a, wdata1_a;
    logic       ack0_a, ack1_a, mem_read_a, mem_write_a;
    logic [7:0] rdata0_a, rdata1_a, address_a, data_src_a, dmo_a;
    logic [7:0] mem_a [256];

    data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_a (
        .CLK(clk), .RST_N(rst_n_a),
        .Req0(req0_a), .We0(we0_a), .Addr0(addr0_a), .WData0(wdata0_a),
        .Ack0(ack0_a), .RData0(rdata0_a),
        .Req1(req1_a), .We1(we1_a), .Addr1(addr1_a), .WData1(wdata1_a),
        .Ack1(ack1_a), .RData1(rdata1_a),
        .MemRead(mem_read_a), .MemWrite(mem_write_a),
        .Address(address_a), .DataSrc(data_src_a), .DataMemOut(dmo_a)
    );

    assign dmo_a = mem_read_a ? mem_a[address_a] : 8'h00;

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_write_a) mem_a[address_a] = data_src_a;
        end
    end

    // ---------------- instance b (fixed priority) ----------------
    logic       rst_n_b;
    logic       req0_b, we0_b, req1_b, we1_b;
    logic [7:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
    logic       ack0_b, ack1_b, mem_read_b, mem_write_b;
    logic [7:0] rdata0_b, rdata1_b, address_b, data_src_b, dmo_b;

    data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_b (
        .CLK(clk), .RST_N(rst_n_b),
        .Req0(req0_b), .We0(we0_b), .Addr0(addr0_b), .WData0(wdata0_b),
        .Ack0(ack0_b), .RData0(rdata0_b),
        .Req1(req1_b), .We1(we1_b), .Addr1(addr1_b), .WData1(wdata1_b),
        .Ack1(ack1_b), .RData1(rdata1_b),
        .MemRead(mem_read_b), .MemWrite(mem_write_b),
        .Address(address_b), .DataSrc(data_src_b), .DataMemOut(dmo_b)
    );

    assign dmo_b = !mem_read_b          ? 8'h00 :
                   (address_b == 8'h40) ? 8'h11 :
                   (address_b == 8'h41) ? 8'h22 : 8'h00;

    // ---------------- scoreboards and monitors ----------------
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [7:0] e_rd0 = 8'h00;
    logic [7:0] e_rd1 = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (ack0_a || ack1_a) begin
            check("one_ack_a", {31'd0, ack0_a & ack1_a}, 0);
            if (sb_a.size() == 0) begin
                check("unexpected_ack_a", {30'd0, ack1_a, ack0_a}, 0);
            end else begin
                e = sb_a.pop_front();
                check("grant_port_a", {31'd0, ack1_a}, {31'd0, e.port});
                check("rdata0_a", {24'd0, rdata0_a}, {24'd0, e.rd0});
                check("rdata1_a", {24'd0, rdata1_a}, {24'd0, e.rd1});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack1_b) check("ack1_while_req0_b", {31'd0, req0_b}, 0);
        if (ack0_b || ack1_b) begin
            if (sb_b.size() == 0) begin
                check("unexpected_ack_b", {30'd0, ack1_b, ack0_b}, 0);
            end else begin
                e = sb_b.pop_front();
                check("grant_port_b", {31'd0, ack1_b}, {31'd0, e.port});
                check("rdata0_b", {24'd0, rdata0_b}, {24'd0, e.rd0});
                check("rdata1_b", {24'd0, rdata1_b}, {24'd0, e.rd1});
            end
        end
    end

    // One isolated transaction on instance a. Entered at posedge+1 with the
    // DUT in IDLE; returns at posedge+1 with the DUT back in IDLE.
    task automatic acc_a(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
        exp_t e;
        if (!we) begin
            if (port) e_rd1 = exp_rd;
            else      e_rd0 = exp_rd;
        end
        e = {port, e_rd0, e_rd1};
        sb_a.push_back(e);
        if (port) begin
            req1_a = 1'b1; we1_a = we; addr1_a = addr; wdata1_a = wdata;
        end else begin
            req0_a = 1'b1; we0_a = we; addr0_a = addr; wdata0_a = wdata;
        end
        @(posedge clk); #1;
        check("mem_write", {31'd0, mem_write_a}, {31'd0, we});
        check("mem_read", {31'd0, mem_read_a}, {31'd0, ~we});
        check("address", {24'd0, address_a}, {24'd0, addr});
        if (we) check("data_src", {24'd0, data_src_a}, {24'd0, wdata});
        @(posedge clk); #1;
        check("ack_latency", {31'd0, port ? ack1_a : ack0_a}, 1);
        req0_a = 1'b0;
        req1_a = 1'b0;
        @(posedge clk); #1;
        check("idle_mem_off", {30'd0, mem_read_a, mem_write_a}, 0);
        check("addr_hold", {24'd0, address_a}, {24'd0, addr});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   n;
        int   last_c;
        logic busy;
        exp_t e;

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        req0_a = 0; we0_a = 0; addr0_a = 0; wdata0_a = 0;
        req1_a = 0; we1_a = 0; addr1_a = 0; wdata1_a = 0;
        req0_b = 0; we0_b = 0; addr0_b = 0; wdata0_b = 0;
        req1_b = 0; we1_b = 0; addr1_b = 0; wdata1_b = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_a", {28'd0, ack0_a, ack1_a, mem_read_a, mem_write_a}, 0);
        check("reset_data_a", {rdata0_a, rdata1_a, address_a, data_src_a}, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle_a", {30'd0, mem_read_a, mem_write_a}, 0);

        // Port 0 write/read, port 1 write/read, top address
        acc_a(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
        acc_a(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        acc_a(1'b1, 1'b1, 8'h30, 8'h5A, 8'h00);
        acc_a(1'b1, 1'b0, 8'h30, 8'h00, 8'h5A);
        acc_a(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00);
        acc_a(1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C);

        // Both ports requesting continuously: round-robin 0,1,0,1,0,1
        e = {1'b0, 8'hA5, 8'h3C}; sb_a.push_back(e);
        e = {1'b1, 8'hA5, 8'h5A}; sb_a.push_back(e);
        e = {1'b0, 8'hA5, 8'h5A}; sb_a.push_back(e);
        e = {1'b1, 8'hA5, 8'h5A}; sb_a.push_back(e);
        e = {1'b0, 8'hA5, 8'h5A}; sb_a.push_back(e);
        e = {1'b1, 8'hA5, 8'h5A}; sb_a.push_back(e);
        e_rd1 = 8'h5A;
        req0_a = 1'b1; we0_a = 1'b0; addr0_a = 8'h10;
        req1_a = 1'b1; we1_a = 1'b0; addr1_a = 8'h30;
        n = 0; last_c = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(posedge clk); #1;
            if (ack0_a || ack1_a) begin
                n++;
                if (n > 1) check("ack_spacing", c - last_c, 3);
                last_c = c;
                if (n == 6) begin
                    req0_a = 1'b0;
                    req1_a = 1'b0;
                end
            end
        end
        check("rr_grant_count", n, 6);
        req0_a = 1'b0; req1_a = 1'b0;
        @(posedge clk); #1;

        // Req0 dropped during ACCESS: the access still completes, once
        e = {1'b0, 8'hA5, 8'h5A}; sb_a.push_back(e);
        req0_a = 1'b1; we0_a = 1'b0; addr0_a = 8'h10;
        @(posedge clk); #1;
        req0_a = 1'b0;
        @(posedge clk); #1;
        check("drop_ack", {31'd0, ack0_a}, 1);
        busy = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            busy = busy | mem_read_a | mem_write_a;
        end
        check("no_second_access", {31'd0, busy}, 0);

        // Reset in the middle of a port 1 write to 0x20
        req1_a = 1'b1; we1_a = 1'b1; addr1_a = 8'h20; wdata1_a = 8'h77;
        @(posedge clk); #1;
        check("rst_write_started", {31'd0, mem_write_a}, 1);
        #2 rst_n_a = 1'b0;
        #1;
        check("async_rst_ctrl", {28'd0, ack0_a, ack1_a, mem_read_a, mem_write_a}, 0);
        check("async_rst_data", {rdata0_a, rdata1_a, address_a, data_src_a}, 0);
        req1_a = 1'b0;
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        e_rd0 = 8'h00; e_rd1 = 8'h00;
        acc_a(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        acc_a(1'b0, 1'b0, 8'h20, 8'h00, 8'h00);

        // Fixed priority: port 0 served four times, then port 1 once it drops
        e = {1'b0, 8'h11, 8'h00};
        repeat (4) sb_b.push_back(e);
        e = {1'b1, 8'h11, 8'h22}; sb_b.push_back(e);
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 8'h40;
        req1_b = 1'b1; we1_b = 1'b0; addr1_b = 8'h41;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(posedge clk); #1;
            if (ack0_b || ack1_b) begin
                n++;
                if (n == 4) req0_b = 1'b0;
                if (n == 5) req1_b = 1'b0;
            end
        end
        check("prio_grant_count", n, 5);
        req0_b = 1'b0; req1_b = 1'b0;

        for (int c = 0; c < 10 && (sb_a.size() != 0 || sb_b.size() != 0); c++)
            @(posedge clk);
        #1;
        check("sb_drain_a", sb_a.size(), 0);
        check("sb_drain_b", sb_b.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
